// File: rtl/sa_feeder.sv
// sa_feeder: input feeder for an N x N output-stationary systolic MAC array.
// Collects N operand vector pairs (column k of A, row k of B), pulses an
// accumulator clear, streams a diagonally skewed, zero-padded wavefront into
// the array's west (A) and north (B) edges, waits for the array to drain and
// then pulses done.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   operand pair handshake (ready only in IDLE/LOAD)
//   a_vec            A[i][k], lane i at [i*DW +: DW]
//   b_vec            B[k][j], lane j at [j*DW +: DW]
//   a_edge           registered feed to array row i
//   b_edge           registered feed to array column j
//   acc_clr          one-cycle accumulator clear
//   pe_en            accumulate enable (STREAM and DRAIN)
//   busy             high outside IDLE
//   done             one-cycle pulse, accumulators hold C = A*B
module sa_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            acc_clr,
  output logic            pe_en,
  output logic            busy,
  output logic            done
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  // Shared stream/drain counter: must hold 0..2N-2.
  localparam int TW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DW-1:0]   a_buf_q [N][N];  // [i][k]
  logic [DW-1:0]   a_buf_d [N][N];
  logic [DW-1:0]   b_buf_q [N][N];  // [k][j]
  logic [DW-1:0]   b_buf_d [N][N];
  logic [N*DW-1:0] a_edge_q, a_edge_d;
  logic [N*DW-1:0] b_edge_q, b_edge_d;
  logic            fire;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign fire     = in_valid && in_ready;
  assign acc_clr  = (state_q == S_CLEAR);
  assign pe_en    = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign a_edge   = a_edge_q;
  assign b_edge   = b_edge_q;

  // Next state, counters and operand buffers.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;

    if (fire) begin
      for (int unsigned l = 0; l < N; l++) begin
        a_buf_d[KW'(l)][k_q] = a_vec[l*DW +: DW];
        b_buf_d[k_q][KW'(l)] = b_vec[l*DW +: DW];
      end
    end

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        // k is 0 in IDLE, so one rule covers the first and later pairs.
        if (fire) begin
          if (k_q == KW'(N - 1)) begin
            state_d = S_CLEAR;
            k_d     = '0;
          end else begin
            state_d = S_LOAD;
            k_d     = k_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (t_q == TW'(2 * N - 2)) begin
          state_d = S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (t_q == TW'(N - 1)) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Edge registers are loaded from the *next* state and counter so that the
  // value for stream step t is visible while state=STREAM and counter=t.
  always_comb begin
    int idx;
    idx      = 0;
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == S_STREAM) begin
      for (int unsigned l = 0; l < N; l++) begin
        idx = int'(t_d) - int'(l);
        if (idx >= 0 && idx < N) begin
          a_edge_d[l*DW +: DW] = a_buf_q[KW'(l)][KW'(idx)];
          b_edge_d[l*DW +: DW] = b_buf_q[KW'(idx)][KW'(l)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      t_q      <= '0;
      a_buf_q  <= '{default: '0};
      b_buf_q  <= '{default: '0};
      a_edge_q <= '0;
      b_edge_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      t_q      <= t_d;
      a_buf_q  <= a_buf_d;
      b_buf_q  <= b_buf_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Directed testbench for sa_feeder. A small behavioural output-stationary
// PE array hangs off the feeder's edges so results can be checked as C = A*B.
module tb_sa_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [N*DW-1:0] b_vec;
  logic [N*DW-1:0] a_edge;
  logic [N*DW-1:0] b_edge;
  logic            acc_clr;
  logic            pe_en;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .a_edge(a_edge), .b_edge(b_edge),
    .acc_clr(acc_clr), .pe_en(pe_en), .busy(busy), .done(done)
  );

  // Behavioural PE array: A moves east, B moves south, acc += A*B.
  logic signed [DW-1:0]   pa  [N][N];
  logic signed [DW-1:0]   pb  [N][N];
  logic        [2*DW-1:0] acc [N][N];

  always @(posedge clk) begin
    logic signed [DW-1:0]   ain, bin;
    logic signed [2*DW-1:0] prod;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain = a_edge[i*DW +: DW];
        else        ain = pa[i][j-1];
        if (i == 0) bin = b_edge[j*DW +: DW];
        else        bin = pb[i-1][j];
        prod = ain * bin;
        if (acc_clr) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else if (pe_en) begin
          acc[i][j] <= acc[i][j] + prod;
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
      end
    end
  end

  int              ma [N][N];
  int              mb [N][N];
  logic [2*DW-1:0] ec [N][N];
  logic [N*DW-1:0] ae [32];
  logic [N*DW-1:0] be [32];
  int              pe_cnt, clr_cnt, rdy_cnt, lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present all N pairs back to back, waiting (bounded) for in_ready.
  task automatic send_job();
    for (int k = 0; k < N; k++) begin
      int guard = 0;
      in_valid = 1'b1;
      for (int l = 0; l < N; l++) begin
        a_vec[l*DW +: DW] = DW'(ma[l][k]);
        b_vec[l*DW +: DW] = DW'(mb[k][l]);
      end
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      check("hs_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called in the cycle after the last handshake (CLEAR); returns the number
  // of cycles from CLEAR through the done cycle inclusive.
  task automatic wait_done(output int n_out);
    int n = 1;
    pe_cnt = 0; clr_cnt = 0; rdy_cnt = 0;
    while (1) begin
      ae[n] = a_edge;
      be[n] = b_edge;
      pe_cnt  += int'(pe_en);
      clr_cnt += int'(acc_clr);
      rdy_cnt += int'(in_ready);
      if (done || n >= 30) break;
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    n_out = n;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), 32'(acc[i][j]), 32'(ec[i][j]));
  endtask

  initial begin
    logic [6:0] pat;
    int kk, dcnt;
    rst = 1'b1; in_valid = 1'b0; a_vec = '0; b_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_edge", 32'(a_edge), 32'd0);
    check("rst_b_edge", 32'(b_edge), 32'd0);
    check("rst_acc_clr", 32'(acc_clr), 32'd0);
    check("rst_pe_en", 32'(pe_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Identity: C = B, latency 13.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * 4 + j + 1;
        ec[i][j] = 16'(i * 4 + j + 1);
      end
    send_job();
    wait_done(lat);
    check("ident_latency", 32'(lat), 32'd13);
    check("ident_pe_en_cycles", 32'(pe_cnt), 32'd11);
    check("ident_clr_cycles", 32'(clr_cnt), 32'd1);
    check_results("ident");
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // A=127, B=-128: every C = -65024 = 0x0200; skew probed on this job.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 127; mb[i][j] = -128; ec[i][j] = 16'h0200;
      end
    send_job();
    wait_done(lat);
    check("mix_latency", 32'(lat), 32'd13);
    check_results("mix");
    check("clear_a_zero", 32'(ae[1]), 32'd0);
    check("clear_b_zero", 32'(be[1]), 32'd0);
    for (int t = 0; t < 7; t++)
      for (int l = 0; l < N; l++) begin
        check($sformatf("skew_a_t%0d_l%0d", t, l), 32'(ae[t+2][l*DW +: DW]),
              (t >= l && t <= l + 3) ? 32'h7f : 32'h0);
        check($sformatf("skew_b_t%0d_l%0d", t, l), 32'(be[t+2][l*DW +: DW]),
              (t >= l && t <= l + 3) ? 32'h80 : 32'h0);
      end
    for (int n = 9; n <= 12; n++) begin
      check($sformatf("drain_a_%0d", n), 32'(ae[n]), 32'd0);
      check($sformatf("drain_b_%0d", n), 32'(be[n]), 32'd0);
    end

    // Back to back: A=B=-128 starts right after done; stale 0x0200 must clear.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -128; mb[i][j] = -128; ec[i][j] = 16'h0000;
      end
    send_job();
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'd13);
    check_results("neg");
    @(posedge clk); #1;

    // Backpressure: in_valid 1,0,0,1,1,0,1 with B=I, so C = A.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i * 4 + j + 1;
        mb[i][j] = (i == j) ? 1 : 0;
        ec[i][j] = 16'(i * 4 + j + 1);
      end
    pat = 7'b1011001;  // bit c = in_valid in cycle c
    kk = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = pat[c];
      if (pat[c]) begin
        for (int l = 0; l < N; l++) begin
          a_vec[l*DW +: DW] = DW'(ma[l][kk]);
          b_vec[l*DW +: DW] = DW'(mb[kk][l]);
        end
        kk++;
      end else begin
        a_vec = {N{8'h55}};
        b_vec = {N{8'h55}};
      end
      check($sformatf("bp_ready_%0d", c), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;  // held high while busy, must be ignored
    a_vec = {N{8'h33}};
    b_vec = {N{8'h33}};
    wait_done(lat);
    in_valid = 1'b0;
    check("bp_latency", 32'(lat), 32'd13);
    check("bp_ready_while_busy", 32'(rdy_cnt), 32'd0);
    check_results("bp");
    @(posedge clk); #1;
    check("bp_idle", 32'(busy), 32'd0);

    // Reset mid-STREAM at t=3.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = -(i * 4 + j + 1);
        ec[i][j] = 16'(-(i * 4 + j + 1));
      end
    send_job();
    repeat (4) begin @(posedge clk); #1; end
    check("mid_in_stream", 32'(pe_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_a_edge", 32'(a_edge), 32'd0);
    check("mid_b_edge", 32'(b_edge), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_pe_en", 32'(pe_en), 32'd0);
    rst = 1'b0;
    dcnt = int'(done);
    repeat (20) begin @(posedge clk); #1; dcnt += int'(done); end
    check("mid_no_done", 32'(dcnt), 32'd0);
    send_job();
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd13);
    check_results("post_rst");
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
